// File: rtl/apb4_pkg.sv
// Shared APB4 register-file definitions: FSM state, PPROT bit positions, strobe-to-mask expansion.
// Declarations only; no latency or backpressure behaviour of its own.
package apb4_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    localparam int PPROT_PRIV_BIT  = 0;
    localparam int PPROT_NSEC_BIT  = 1;
    localparam int PPROT_INSTR_BIT = 2;

    // One strobe bit covers one byte lane of write data.
    function automatic logic [7:0] strb_lane_mask(input logic strb);
        return {8{strb}};
    endfunction

endpackage

// File: rtl/apb4_wait_fsm.sv
// APB4 setup/access sequencer: ready after WAIT_STATES+1 access cycles, commit marks a completing write.
// PSEL dropping during access aborts the transfer; nothing commits.
module apb4_wait_fsm
    import apb4_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic psel_i,
    input  logic penable_i,
    input  logic pwrite_i,
    output logic ready,
    output logic commit
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    assign ready  = (state_q == ST_ACCESS) && psel_i && penable_i && (cnt_q == WS);
    assign commit = ready && pwrite_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel_i && !penable_i) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (ready || !psel_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < WS) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/apb4_param_regfile.sv
// APB4 register file with per-register RO / W1C / secure attributes and hardware inputs.
// Completes after WAIT_STATES+1 access cycles; PREADY is held low for the wait cycles.
module apb4_param_regfile
    import apb4_pkg::*;
#(
    parameter int                               DATA_WIDTH  = 32,
    parameter int                               ADDR_WIDTH  = 32,
    parameter int                               NUM_REGS    = 16,
    parameter int                               WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]              RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]              W1C_MASK    = '0,
    parameter logic [NUM_REGS-1:0]              SEC_MASK    = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0]   RST_VAL     = '0
) (
    input  logic                             PCLK,
    input  logic                             PRESETn,
    input  logic                             PSEL,
    input  logic                             PENABLE,
    input  logic                             PWRITE,
    input  logic [ADDR_WIDTH-1:0]            PADDR,
    input  logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [DATA_WIDTH/8-1:0]          PSTRB,
    input  logic [2:0]                       PPROT,
    output logic                             PREADY,
    output logic [DATA_WIDTH-1:0]            PRDATA,
    output logic                             PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]   hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TOP_LSB    = 2 + IDX_W;

    logic [IDX_W-1:0]                     idx;
    logic [NUM_REGS-1:0]                  sel;
    logic                                 addr_hi_err;
    logic                                 err;
    logic                                 ready;
    logic                                 commit;
    logic                                 wr_en;
    logic [DATA_WIDTH-1:0]                wmask;
    logic [DATA_WIDTH-1:0]                rd_val;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  rd_vals;
    logic                                 unused_in;

    // Only RO and W1C registers consume hw_in; PPROT privilege/instruction bits are ignored.
    assign unused_in = ^{hw_in, PPROT[PPROT_PRIV_BIT], PPROT[PPROT_INSTR_BIT]};

    assign idx = PADDR[2 +: IDX_W];

    if (ADDR_WIDTH > TOP_LSB) begin : g_hi
        assign addr_hi_err = |PADDR[ADDR_WIDTH-1:TOP_LSB];
    end else begin : g_no_hi
        assign addr_hi_err = 1'b0;
    end

    // An empty one-hot select also covers index >= NUM_REGS.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sel
        assign sel[i] = (idx == IDX_W'(i));
    end

    assign err = (PADDR[1:0] != 2'b00)
               | addr_hi_err
               | ~(|sel)
               | (PWRITE & (|(sel & RO_MASK)))
               | (PPROT[PPROT_NSEC_BIT] & (|(sel & SEC_MASK)));

    always_comb begin
        wmask = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            wmask[b*8 +: 8] = strb_lane_mask(PSTRB[b]);
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel[i]) rd_val = rd_vals[i];
        end
    end

    apb4_wait_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk_i     (PCLK),
        .rst_n_i   (PRESETn),
        .psel_i    (PSEL),
        .penable_i (PENABLE),
        .pwrite_i  (PWRITE),
        .ready     (ready),
        .commit    (commit)
    );

    assign wr_en   = commit & ~err;
    assign PREADY  = ready;
    assign PSLVERR = ready & err;
    assign PRDATA  = (ready && !PWRITE && !err) ? rd_val : '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RV = RST_VAL[i*DATA_WIDTH +: DATA_WIDTH];
        if (RO_MASK[i]) begin : g_ro
            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = RV;
            assign rd_vals[i] = hw_in[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] val_q, val_d;
            logic                  wr;
            assign wr = wr_en & sel[i];

            // For W1C the hardware set is applied after the clear, so set wins.
            always_comb begin
                val_d = val_q;
                if (W1C_MASK[i]) begin
                    if (wr) val_d = val_q & ~(PWDATA & wmask);
                    val_d = val_d | hw_in[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (wr) begin
                    val_d = (val_q & ~wmask) | (PWDATA & wmask);
                end
            end

            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn) val_q <= RV;
                else          val_q <= val_d;
            end

            assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = val_q;
            assign rd_vals[i] = val_q;
        end
    end

    mask_overlap_a: assert property (@(posedge PCLK) (RO_MASK & W1C_MASK) == '0)
        else $error("apb4_param_regfile: RO_MASK and W1C_MASK overlap");

endmodule

// File: tb/tb_apb4_param_regfile.sv
// Bench for apb4_param_regfile: a zero-wait and a three-wait instance share one APB bus,
// every transfer runs until the slower instance completes, results compared with an array model.
module tb_apb4_param_regfile;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 6;
    localparam logic [NR-1:0]    RO_M  = 6'b100000;
    localparam logic [NR-1:0]    W1C_M = 6'b001000;
    localparam logic [NR-1:0]    SEC_M = 6'b010000;
    localparam logic [NR*DW-1:0] RST_V = {32'hDEAD_BEEF, 32'h4444_4444, 32'h0000_000F,
                                          32'h2222_2222, 32'h1111_0001, 32'h0000_0000};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n = 1'b1;
    logic           psel, penable, pwrite;
    logic [AW-1:0]  paddr;
    logic [DW-1:0]  pwdata;
    logic [3:0]     pstrb;
    logic [2:0]     pprot;
    logic [NR*DW-1:0] hw_in, reg_out0, reg_out3;
    logic           pready0, pready3, pslverr0, pslverr3;
    logic [DW-1:0]  prdata0, prdata3;

    logic [31:0] mdl [NR];
    int n_pass, n_total;

    apb4_param_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(0),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .SEC_MASK(SEC_M), .RST_VAL(RST_V)) dut0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PREADY(pready0),
        .PRDATA(prdata0), .PSLVERR(pslverr0), .hw_in(hw_in), .reg_out(reg_out0));

    apb4_param_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(3),
        .RO_MASK(RO_M), .W1C_MASK(W1C_M), .SEC_MASK(SEC_M), .RST_VAL(RST_V)) dut3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PREADY(pready3),
        .PRDATA(prdata3), .PSLVERR(pslverr3), .hw_in(hw_in), .reg_out(reg_out3));

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = RST_V[i*DW +: DW];
    endtask

    function automatic logic model_err(input logic wr, input logic [AW-1:0] addr, input logic [2:0] prot);
        int idx;
        idx = int'(addr) / 4;
        if (int'(addr) % 4 != 0) return 1'b1;
        if (idx >= NR) return 1'b1;
        if (wr && RO_M[idx]) return 1'b1;
        if (prot[1] && SEC_M[idx]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [AW-1:0] addr);
        int idx;
        idx = int'(addr) / 4;
        if (RO_M[idx]) return hw_in[idx*DW +: DW];
        return mdl[idx];
    endfunction

    task automatic model_write(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
        int idx;
        idx = int'(addr) / 4;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                if (W1C_M[idx]) mdl[idx][b*8 +: 8] = mdl[idx][b*8 +: 8] & ~wdata[b*8 +: 8];
                else            mdl[idx][b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        if (W1C_M[idx]) mdl[idx] = mdl[idx] | hw_in[idx*DW +: DW];
    endtask

    function automatic logic [NR*DW-1:0] model_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO_M[i] ? RST_V[i*DW +: DW] : mdl[i];
        return v;
    endfunction

    // ---------------- bus driver ----------------
    // lat = access cycles before PREADY (-1 if never); early flags nonzero outputs before PREADY.
    task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rd0, output logic [31:0] rd3,
                            output logic err0, output logic err3,
                            output int lat0, output int lat3, output logic early);
        logic got0;
        rd0 = '0; rd3 = '0; err0 = 1'b0; err3 = 1'b0; lat0 = -1; lat3 = -1; early = 1'b0; got0 = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (pready0 && !got0) begin
                got0 = 1'b1; lat0 = n; rd0 = prdata0; err0 = pslverr0;
            end
            if (pready3) begin
                lat3 = n; rd3 = prdata3; err3 = pslverr3;
                break;
            end
            if (prdata3 != '0 || pslverr3) early = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = '0;
        #1 rst_n = 1'b0;
        #2;
        n_total++; if (pready0 !== 1'b0 || pready3 !== 1'b0) $display("FAIL reset_pready got %b%b want 00", pready0, pready3); else n_pass++;
        n_total++; if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) $display("FAIL reset_pslverr got %b%b want 00", pslverr0, pslverr3); else n_pass++;
        n_total++; if (prdata0 !== '0 || prdata3 !== '0) $display("FAIL reset_prdata got %h %h want 0", prdata0, prdata3); else n_pass++;
        n_total++; if (reg_out0 !== RST_V) $display("FAIL reset_regs0 got %h want %h", reg_out0, RST_V); else n_pass++;
        n_total++; if (reg_out3 !== RST_V) $display("FAIL reset_regs3 got %h want %h", reg_out3, RST_V); else n_pass++;
        repeat (2) @(posedge clk);
        #1; psel = 1'b0; penable = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] rd0, rd3; logic e0, e3, early; int l0, l3;
        apb_xfer(1'b1, 12'h008, 32'hA5A5_1234, 4'hF, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        model_write(12'h008, 32'hA5A5_1234, 4'hF);
        n_total++; if (l0 != 0 || e0 !== 1'b0) $display("FAIL basic_wr_lat0 got lat=%0d err=%b want lat=0 err=0", l0, e0); else n_pass++;
        apb_xfer(1'b0, 12'h008, 32'h0, 4'h0, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (l0 != 0) $display("FAIL basic_rd_lat0 got %0d want 0", l0); else n_pass++;
        n_total++; if (rd0 !== 32'hA5A5_1234 || e0 !== 1'b0) $display("FAIL basic_rd0 got %h err=%b want a5a51234 err=0", rd0, e0); else n_pass++;
        n_total++; if (rd3 !== 32'hA5A5_1234 || e3 !== 1'b0) $display("FAIL basic_rd3 got %h err=%b want a5a51234 err=0", rd3, e3); else n_pass++;
    endtask

    task automatic test_wait_states();
        logic [31:0] rd0, rd3; logic e0, e3, early; int l0, l3;
        apb_xfer(1'b0, 12'h004, 32'h0, 4'hF, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (l3 != 3) $display("FAIL wait_lat3 got %0d want 3", l3); else n_pass++;
        n_total++; if (l0 != 0) $display("FAIL wait_lat0 got %0d want 0", l0); else n_pass++;
        n_total++; if (early !== 1'b0) $display("FAIL wait_outputs_before_ready got %b want 0", early); else n_pass++;
        n_total++; if (rd3 !== mdl[1] || e3 !== 1'b0) $display("FAIL wait_rd3 got %h err=%b want %h err=0", rd3, e3, mdl[1]); else n_pass++;
    endtask

    task automatic test_strobe();
        logic [31:0] rd0, rd3; logic e0, e3, early; int l0, l3;
        apb_xfer(1'b1, 12'h000, 32'hFFFF_FFFF, 4'h2, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        model_write(12'h000, 32'hFFFF_FFFF, 4'h2);
        apb_xfer(1'b0, 12'h000, 32'h0, 4'h0, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (rd0 !== 32'h0000_FF00) $display("FAIL strobe_rd0 got %h want 0000ff00", rd0); else n_pass++;
        n_total++; if (rd3 !== 32'h0000_FF00) $display("FAIL strobe_rd3 got %h want 0000ff00", rd3); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] rd0, rd3; logic e0, e3, early; int l0, l3;
        logic [AW-1:0] ea [5] = '{12'h005, 12'h018, 12'h014, 12'h010, 12'h020};
        logic          ew [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [2:0]    ep [5] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000};
        hw_in[5*DW +: DW] = 32'h5A5A_0FF0;
        for (int k = 0; k < 5; k++) begin
            apb_xfer(ew[k], ea[k], $urandom, 4'hF, ep[k], rd0, rd3, e0, e3, l0, l3, early);
            n_total++; if (e0 !== 1'b1 || e3 !== 1'b1) $display("FAIL err_flag[%0d] got %b%b want 11", k, e0, e3); else n_pass++;
            n_total++; if (rd0 !== '0 || rd3 !== '0) $display("FAIL err_rdata[%0d] got %h %h want 0", k, rd0, rd3); else n_pass++;
            n_total++; if (reg_out0 !== model_vec() || reg_out3 !== model_vec()) $display("FAIL err_regs[%0d] got %h want %h", k, reg_out3, model_vec()); else n_pass++;
        end
        apb_xfer(1'b0, 12'h010, 32'h0, 4'h0, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (e3 !== 1'b0 || rd3 !== mdl[4]) $display("FAIL sec_ok_read got %h err=%b want %h err=0", rd3, e3, mdl[4]); else n_pass++;
        apb_xfer(1'b0, 12'h014, 32'h0, 4'h0, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (e3 !== 1'b0 || rd3 !== 32'h5A5A_0FF0) $display("FAIL ro_read_hw got %h err=%b want 5a5a0ff0 err=0", rd3, e3); else n_pass++;
    endtask

    task automatic test_w1c();
        logic [31:0] rd0, rd3; logic e0, e3, early; int l0, l3;
        hw_in[3*DW +: DW] = 32'h0000_0001;
        apb_xfer(1'b1, 12'h00C, 32'h0000_0003, 4'hF, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        model_write(12'h00C, 32'h0000_0003, 4'hF);
        apb_xfer(1'b0, 12'h00C, 32'h0, 4'h0, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        n_total++; if (rd0 !== 32'h0000_000D) $display("FAIL w1c_rd0 got %h want 0000000d", rd0); else n_pass++;
        n_total++; if (rd3 !== 32'h0000_000D) $display("FAIL w1c_rd3 got %h want 0000000d", rd3); else n_pass++;
        hw_in[3*DW +: DW] = 32'h0;
    endtask

    task automatic test_abort();
        logic [31:0] rd0, rd3, v, v2; logic e0, e3, early; int l0, l3;
        v = $urandom; v2 = ~v;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = v; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1; penable = 1'b1;
        @(negedge clk);
        n_total++; if (pready3 !== 1'b0) $display("FAIL abort_ready3_early got %b want 0", pready3); else n_pass++;
        @(posedge clk); #1; psel = 1'b0; penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++; if (reg_out3[1*DW +: DW] !== mdl[1]) $display("FAIL abort_no_commit got %h want %h", reg_out3[1*DW +: DW], mdl[1]); else n_pass++;
        n_total++; if (reg_out0[1*DW +: DW] !== v) $display("FAIL abort_fast_commit got %h want %h", reg_out0[1*DW +: DW], v); else n_pass++;
        apb_xfer(1'b1, 12'h004, v2, 4'hF, 3'b000, rd0, rd3, e0, e3, l0, l3, early);
        model_write(12'h004, v2, 4'hF);
        n_total++; if (reg_out3 !== model_vec() || l3 != 3) $display("FAIL abort_recover got %h lat=%0d want %h lat=3", reg_out3, l3, model_vec()); else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] rd0, rd3, wd, exp_rd; logic e0, e3, early, wr, exp_err; int l0, l3;
        logic [AW-1:0] addr; logic [3:0] strb; logic [2:0] prot;
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < NR; i++) hw_in[i*DW +: DW] = (i == 3) ? 32'h0 : $urandom;
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       addr = AW'($urandom_range(0, 4095));
                1:       addr = AW'($urandom_range(0, NR - 1) * 4 + $urandom_range(1, 3));
                default: addr = AW'($urandom_range(0, NR - 1) * 4);
            endcase
            wd = $urandom; strb = 4'($urandom_range(0, 15)); prot = 3'($urandom_range(0, 7));
            exp_err = model_err(wr, addr, prot);
            exp_rd  = (!wr && !exp_err) ? model_read(addr) : 32'h0;
            apb_xfer(wr, addr, wd, strb, prot, rd0, rd3, e0, e3, l0, l3, early);
            if (wr && !exp_err) model_write(addr, wd, strb);
            n_total++; if (e0 !== exp_err || e3 !== exp_err) $display("FAIL rnd_err[%0d] addr=%h wr=%b got %b%b want %b", it, addr, wr, e0, e3, exp_err); else n_pass++;
            n_total++; if (rd0 !== exp_rd || rd3 !== exp_rd) $display("FAIL rnd_rd[%0d] addr=%h got %h %h want %h", it, addr, rd0, rd3, exp_rd); else n_pass++;
            n_total++; if (l0 != 0 || l3 != 3 || early) $display("FAIL rnd_lat[%0d] got %0d/%0d early=%b want 0/3 early=0", it, l0, l3, early); else n_pass++;
            n_total++; if (reg_out0 !== model_vec() || reg_out3 !== model_vec()) $display("FAIL rnd_regs[%0d] got %h want %h", it, reg_out3, model_vec()); else n_pass++;
        end
    endtask

    task automatic test_reset_in_wait();
        int got;
        // Reset during a wait cycle of a write.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h008; pwdata = 32'h1234_5678; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1; penable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (reg_out0[2*DW +: DW] !== 32'h1234_5678) $display("FAIL rstw_fast_commit got %h want 12345678", reg_out0[2*DW +: DW]); else n_pass++;
        rst_n = 1'b0; #1;
        n_total++; if (pready3 !== 1'b0 || pslverr3 !== 1'b0 || prdata3 !== '0) $display("FAIL rstw_outputs got %b %b %h want 0 0 0", pready3, pslverr3, prdata3); else n_pass++;
        n_total++; if (reg_out0 !== RST_V) $display("FAIL rstw_async_regs got %h want %h", reg_out0, RST_V); else n_pass++;
        @(posedge clk); #1; rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        n_total++; if (reg_out3 !== RST_V) $display("FAIL rstw_no_commit got %h want %h", reg_out3, RST_V); else n_pass++;
        model_reset();
        // Reset while a read is completing drops PREADY and PRDATA at once.
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h004;
        @(posedge clk); #1; penable = 1'b1;
        got = 0;
        for (int n = 0; n < 20 && got == 0; n++) begin
            @(negedge clk);
            if (pready3) got = 1;
        end
        n_total++; if (got != 1 || prdata3 !== mdl[1]) $display("FAIL rstr_before got ready=%0d data=%h want 1 %h", got, prdata3, mdl[1]); else n_pass++;
        rst_n = 1'b0; #1;
        n_total++; if (pready3 !== 1'b0 || prdata3 !== '0) $display("FAIL rstr_async got %b %h want 0 0", pready3, prdata3); else n_pass++;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0; n_total = 0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        hw_in = '0;
        model_reset();
        test_reset();
        test_basic();
        test_wait_states();
        test_strobe();
        test_errors();
        test_w1c();
        test_abort();
        test_random();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/apb4_param_regfile.md
APB4_PARAM_REGFILE -- requirements
Module: apb4_param_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width, a multiple of 8; STRB_WIDTH = DATA_WIDTH/8.
REQ-002 Parameter ADDR_WIDTH, default 32: PADDR width.
REQ-003 Parameter NUM_REGS, default 16: register count, 1..256; IDX_W = max(1, clog2(NUM_REGS)).
REQ-004 Parameter WAIT_STATES, default 0: wait cycles inserted per transfer, 0..15.
REQ-005 Parameter RO_MASK, default all 0 (NUM_REGS bits): bit i=1 makes register i read-only.
REQ-006 Parameter W1C_MASK, default all 0 (NUM_REGS bits): bit i=1 makes register i sticky write-one-to-clear.
REQ-007 Parameter SEC_MASK, default all 0 (NUM_REGS bits): bit i=1 makes register i secure-only.
REQ-008 Parameter RST_VAL, default 0 (NUM_REGS*DATA_WIDTH bits): per-register reset value.
REQ-009 PCLK  in  1  sole clock; all state is updated on the rising edge.
REQ-010 PRESETn  in  1  asynchronous, active-low reset.
REQ-011 PSEL  in  1  slave select.
REQ-012 PENABLE  in  1  access phase.
REQ-013 PWRITE  in  1  1=write, 0=read.
REQ-014 PADDR  in  ADDR_WIDTH  byte address.
REQ-015 PWDATA  in  DATA_WIDTH  write data.
REQ-016 PSTRB  in  STRB_WIDTH  byte-lane write strobes.
REQ-017 PPROT  in  3  protection; PPROT[1]=1 marks a non-secure access.
REQ-018 PREADY  out  1  transfer complete.
REQ-019 PRDATA  out  DATA_WIDTH  read data.
REQ-020 PSLVERR  out  1  transfer error.
REQ-021 hw_in  in  NUM_REGS*DATA_WIDTH  hardware value per register; slice i = [i*DATA_WIDTH +: DATA_WIDTH].
REQ-022 reg_out  out  NUM_REGS*DATA_WIDTH  current stored value of every register, same slicing.

Function
REQ-023 The FSM SHALL have two states: IDLE and ACCESS.
- IDLE -> ACCESS when PSEL=1 and PENABLE=0; the wait counter clears to 0.
REQ-024 In ACCESS, the wait counter SHALL increment by 1 per cycle while it is below WAIT_STATES.
REQ-025 PREADY SHALL be 1 only when state=ACCESS, PSEL=1, PENABLE=1 and counter=WAIT_STATES.
- With WAIT_STATES=0 the transfer completes in its first access cycle.
- Each transfer takes exactly WAIT_STATES extra cycles.
REQ-026 ACCESS SHALL return to IDLE on the edge where PREADY=1, or where PSEL=0 (abort).
- An abort commits nothing.
REQ-027 Decode: index = PADDR[2 +: IDX_W].
- Error when PADDR[1:0]!=0.
- Error when any PADDR bit at or above 2+IDX_W is set, or when index>=NUM_REGS.
- Error when a write targets an RO register.
- Error when PPROT[1]=1 and SEC_MASK[index]=1.
REQ-028 PSLVERR SHALL equal the error decode while PREADY=1, and 0 otherwise.
REQ-029 An erroring transfer SHALL leave all registers unchanged and drive PRDATA=0.
REQ-030 RW write, committed on the PREADY edge: reg = (reg & ~m) | (PWDATA & m), where m expands each PSTRB bit to 8 bits.
REQ-031 W1C write: reg = reg & ~(PWDATA & m).
- Every cycle, W1C register i also sets reg |= hw_in slice i.
- When set and clear hit the same bit in one cycle, set SHALL win.
REQ-032 Reads SHALL ignore PSTRB.
- RO registers read hw_in slice i combinationally.
- RW and W1C registers read the stored value.
- PRDATA SHALL be valid only while PREADY=1 and read, and 0 at all other times.
REQ-033 reg_out for an RO register SHALL be RST_VAL slice i, which is constant.
REQ-034 RO_MASK & W1C_MASK SHALL be 0; a simulation-time assertion SHALL flag any overlap.

Reset
REQ-035 While PRESETn=0, the following SHALL hold immediately and asynchronously:
- state=IDLE and counter=0;
- PREADY=0, PSLVERR=0, PRDATA=0;
- every register = its RST_VAL slice.
REQ-036 A reset during ACCESS SHALL abort the transfer with no register update.

Structure
REQ-037 Package apb4_pkg SHALL hold the FSM state enum, the PPROT bit-index constants and the strobe-mask expansion function.
REQ-038 The FSM and wait counter SHALL live in sub-module apb4_wait_fsm, with outputs ready and commit.

Verification
REQ-039 WAIT_STATES=0: write 0xA5A5_1234 to 0x08 with PSTRB=0xF, then read 0x08 -> PREADY in the first access cycle, PRDATA=0xA5A5_1234, PSLVERR=0.
REQ-040 WAIT_STATES=3: a read of 0x04 -> PREADY low for 3 access cycles, high on the 4th.
REQ-041 Write 0xFFFF_FFFF with PSTRB=0x2 to RW reg 0 (value 0) -> read returns 0x0000_FF00.
REQ-042 Error cases, each with PSLVERR=1, PRDATA=0 and no register change:
- PADDR=0x05;
- index=NUM_REGS;
- write to an RO register;
- PPROT=3'b010 to a SEC register.
REQ-043 W1C reg holds 0x0F and hw_in=0x01 while a write of 0x03 commits -> read returns 0x0D.
REQ-044 Assert PRESETn=0 during a wait cycle of a write -> outputs 0 at once; the register keeps RST_VAL.
